ps2_keyboard_rx: RTL and testbench

Receiver for a PS/2 keyboard (scan code set 2). It deserialises device-to-host frames from the PS/2 clock and data lines and resolves the E0, F0 and E1 prefixes. It then drives the keyboard event interface consumed by the machine core: one-cycle strb, with make and code valid alongside it. It sits between the board PS/2 pins and the keyboard matrix block, in the 56 MHz clock domain.

---
 rtl/ps2_keyboard_rx_if.sv | 11 +
 rtl/ps2_keyboard_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_rx_if.sv
// Keyboard event bundle from the PS/2 receiver to the keyboard matrix block.
interface ps2_keyboard_rx_if;
    logic       strb;
    logic       make;
    logic       ext;
    logic [7:0] code;
    logic       err;

    modport master (output strb, output make, output ext, output code, output err);
    modport slave  (input  strb, input  make, input  ext, input  code, input  err);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver (scan code set 2): conditions the pins, deframes bytes,
// resolves E0/F0/E1 prefixes and emits one-cycle key events.
module ps2_keyboard_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 11200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ps2Ck,
    input  logic              ps2D,
    ps2_keyboard_rx_if.master kbd
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^{data, par}) == 1'b1;
    endfunction

    function automatic logic is_reply(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic          ck_s1_q, ck_s2_q, d_s1_q, d_s2_q;
    logic          fck_q, fck_d, fck_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_e        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_flag_q, ext_flag_d;
    logic          brk_flag_q, brk_flag_d;
    logic [2:0]    skip_q, skip_d;
    logic          strb_q, strb_d;
    logic          err_q, err_d;
    logic          make_q, make_d;
    logic          ext_q, ext_d;
    logic [7:0]    code_q, code_d;
    logic          fall_s;
    logic          bit_s;

    assign fall_s = fck_prev_q & ~fck_q;
    assign bit_s  = d_s2_q;

    // Pin synchronisers, glitch filter and edge-detect history.
    always_ff @(posedge clock) begin
        if (reset) begin
            ck_s1_q    <= 1'b1;
            ck_s2_q    <= 1'b1;
            d_s1_q     <= 1'b1;
            d_s2_q     <= 1'b1;
            fck_q      <= 1'b1;
            fck_prev_q <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            ck_s1_q    <= ps2Ck;
            ck_s2_q    <= ck_s1_q;
            d_s1_q     <= ps2D;
            d_s2_q     <= d_s1_q;
            fck_q      <= fck_d;
            fck_prev_q <= fck_q;
            fcnt_q     <= fcnt_d;
        end
    end

    // Filter: fck follows the pin only after FILTER consecutive differing samples.
    always_comb begin
        fck_d  = fck_q;
        fcnt_d = '0;
        if (ck_s2_q != fck_q) begin
            if (fcnt_q == FW'(FILTER - 1)) begin
                fck_d  = ~fck_q;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end else begin
            fcnt_d = '0;
        end
    end

    // Frame FSM, timeout, prefix tracking and event output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 3'd0;
            shreg_q    <= 8'h00;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            ext_flag_q <= 1'b0;
            brk_flag_q <= 1'b0;
            skip_q     <= 3'd0;
            strb_q     <= 1'b0;
            err_q      <= 1'b0;
            make_q     <= 1'b0;
            ext_q      <= 1'b0;
            code_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            ext_flag_q <= ext_flag_d;
            brk_flag_q <= brk_flag_d;
            skip_q     <= skip_d;
            strb_q     <= strb_d;
            err_q      <= err_d;
            make_q     <= make_d;
            ext_q      <= ext_d;
            code_q     <= code_d;
        end
    end

    // Next-state: deframing on filtered falls; the byte is decoded on the stop fall.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        ext_flag_d = ext_flag_q;
        brk_flag_d = brk_flag_q;
        skip_d     = skip_q;
        strb_d     = 1'b0;
        err_d      = 1'b0;
        make_d     = make_q;
        ext_d      = ext_q;
        code_d     = code_q;

        if (fall_s || (state_q == ST_IDLE)) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (fall_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bit_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {bit_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_d   = bit_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (odd_parity_ok(shreg_q, par_q) && bit_s) begin
                        if (skip_q != 3'd0) begin
                            // Pause sequence: swallow the 7 trailing bytes, report once.
                            skip_d = skip_q - 3'd1;
                            if (skip_q == 3'd1) begin
                                strb_d = 1'b1;
                                make_d = 1'b1;
                                ext_d  = 1'b0;
                                code_d = 8'hE1;
                            end else begin
                                strb_d = 1'b0;
                            end
                        end else if (shreg_q == 8'hE1) begin
                            skip_d = 3'd7;
                        end else if (shreg_q == 8'hE0) begin
                            ext_flag_d = 1'b1;
                        end else if (shreg_q == 8'hF0) begin
                            brk_flag_d = 1'b1;
                        end else if (is_reply(shreg_q) && !ext_flag_q && !brk_flag_q) begin
                            strb_d = 1'b0;
                        end else begin
                            strb_d     = 1'b1;
                            make_d     = ~brk_flag_q;
                            ext_d      = ext_flag_q;
                            code_d     = shreg_q;
                            ext_flag_d = 1'b0;
                            brk_flag_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        ext_flag_d = 1'b0;
                        brk_flag_d = 1'b0;
                        skip_d     = 3'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT - 1))) begin
            state_d    = ST_IDLE;
            to_cnt_d   = '0;
            err_d      = 1'b1;
            ext_flag_d = 1'b0;
            brk_flag_d = 1'b0;
            skip_d     = 3'd0;
        end else begin
            state_d = state_q;
        end
    end

    assign kbd.strb = strb_q;
    assign kbd.make = make_q;
    assign kbd.ext  = ext_q;
    assign kbd.code = code_q;
    assign kbd.err  = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames on the pins and
// checks decoded key events, error pulses and latency against hand values.
module tb_ps2_keyboard_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 400;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2Ck = 1'b1;
    logic ps2D  = 1'b1;

    ps2_keyboard_rx_if kbd_if ();

    ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .ps2Ck (ps2Ck),
        .ps2D  (ps2D),
        .kbd   (kbd_if)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int strb_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    int strb_cyc = 0;
    logic strb_prev = 1'b0;
    int stop_cyc;
    int s0, e0;

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor, sampled on the falling clock edge.
    always @(negedge clock) begin
        if (kbd_if.strb) begin
            strb_cnt <= strb_cnt + 1;
            strb_cyc <= cyc;
        end
        if (kbd_if.err) err_cnt <= err_cnt + 1;
        if (kbd_if.strb && kbd_if.err) both_cnt <= both_cnt + 1;
        if (kbd_if.strb && strb_prev) wide_cnt <= wide_cnt + 1;
        strb_prev <= kbd_if.strb;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2D = b;
        tick(20);
        ps2Ck = 1'b0;
        stop_cyc = cyc;
        tick(40);
        ps2Ck = 1'b1;
        tick(20);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2D = 1'b1;
        tick(60);
    endtask

    task automatic mark();
        s0 = strb_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        tick(5);
        reset = 1'b0;
        tick(3);
        chk("rst_strb", {31'd0, kbd_if.strb}, 32'd0);
        chk("rst_make", {31'd0, kbd_if.make}, 32'd0);
        chk("rst_ext",  {31'd0, kbd_if.ext},  32'd0);
        chk("rst_code", {24'd0, kbd_if.code}, 32'h00);
        chk("rst_err",  {31'd0, kbd_if.err},  32'd0);

        // Plain make code, with stop-fall-to-strobe latency.
        mark();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("mk1c_strb", strb_cnt - s0, 32'd1);
        chk("mk1c_err",  err_cnt - e0,  32'd0);
        chk("mk1c_make", {31'd0, kbd_if.make}, 32'd1);
        chk("mk1c_ext",  {31'd0, kbd_if.ext},  32'd0);
        chk("mk1c_code", {24'd0, kbd_if.code}, 32'h1C);
        chk("mk1c_lat",  strb_cyc - stop_cyc,  32'd11);

        mark();
        send_frame(8'hF0, 1'b0, 1'b0);
        chk("f0_nostrb", strb_cnt - s0, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("brk_strb", strb_cnt - s0, 32'd1);
        chk("brk_make", {31'd0, kbd_if.make}, 32'd0);
        chk("brk_ext",  {31'd0, kbd_if.ext},  32'd0);
        chk("brk_code", {24'd0, kbd_if.code}, 32'h1C);

        mark();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        chk("xbrk_strb", strb_cnt - s0, 32'd1);
        chk("xbrk_make", {31'd0, kbd_if.make}, 32'd0);
        chk("xbrk_ext",  {31'd0, kbd_if.ext},  32'd1);
        chk("xbrk_code", {24'd0, kbd_if.code}, 32'h74);
        send_frame(8'h74, 1'b0, 1'b0);
        chk("mk74_strb", strb_cnt - s0, 32'd2);
        chk("mk74_make", {31'd0, kbd_if.make}, 32'd1);
        chk("mk74_ext",  {31'd0, kbd_if.ext},  32'd0);

        // Reply byte with no prefix is dropped silently.
        mark();
        send_frame(8'hAA, 1'b0, 1'b0);
        chk("aa_strb", strb_cnt - s0, 32'd0);
        chk("aa_err",  err_cnt - e0,  32'd0);

        send_frame(8'h1C, 1'b0, 1'b0);
        mark();
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("par_err",  err_cnt - e0,  32'd1);
        chk("par_strb", strb_cnt - s0, 32'd0);
        chk("par_code", {24'd0, kbd_if.code}, 32'h1C);
        mark();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("stop_err",  err_cnt - e0,  32'd1);
        chk("stop_strb", strb_cnt - s0, 32'd0);

        // A bad frame clears a pending E0.
        mark();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("clr_err",  err_cnt - e0,  32'd1);
        chk("clr_strb", strb_cnt - s0, 32'd1);
        chk("clr_ext",  {31'd0, kbd_if.ext},  32'd0);
        chk("clr_make", {31'd0, kbd_if.make}, 32'd1);

        // Partial frame abandoned by the timeout.
        mark();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        tick(2 * TIMEOUT);
        chk("to_err",  err_cnt - e0,  32'd1);
        chk("to_strb", strb_cnt - s0, 32'd0);

        // Short clock glitches with data low must not start a frame.
        mark();
        ps2D = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2Ck = 1'b0;
            tick(FILTER / 2);
            ps2Ck = 1'b1;
            tick(30);
        end
        ps2D = 1'b1;
        tick(TIMEOUT + 50);
        chk("gl_err", err_cnt - e0, 32'd0);
        send_frame(8'h2D, 1'b0, 1'b0);
        chk("gl_strb", strb_cnt - s0, 32'd1);
        chk("gl_err2", err_cnt - e0,  32'd0);
        chk("gl_code", {24'd0, kbd_if.code}, 32'h2D);

        // Pause key sequence.
        mark();
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        chk("e1_mid", strb_cnt - s0, 32'd0);
        send_frame(8'h77, 1'b0, 1'b0);
        chk("e1_strb", strb_cnt - s0, 32'd1);
        chk("e1_make", {31'd0, kbd_if.make}, 32'd1);
        chk("e1_ext",  {31'd0, kbd_if.ext},  32'd0);
        chk("e1_code", {24'd0, kbd_if.code}, 32'hE1);

        // Reset in the middle of a frame.
        mark();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        ps2D = 1'b1;
        tick(20);
        chk("mr_code0", {24'd0, kbd_if.code}, 32'h00);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("mr_strb", strb_cnt - s0, 32'd1);
        chk("mr_err",  err_cnt - e0,  32'd0);
        chk("mr_code", {24'd0, kbd_if.code}, 32'h1C);

        chk("both_high", both_cnt, 32'd0);
        chk("strb_wide", wide_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
